// File: rtl/rm_sched_pkg.sv
// Shared types and constants for the ISS step scheduler.
package rm_sched_pkg;

    // Width of the interrupt cause carried with each retire entry
    localparam int CAUSE_W = 11;

    // Default width of the RVFI order tag
    localparam int ORDER_W = 64;

    // Scheduler control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IRQ_UPD = 2'd1,
        STEP    = 2'd2
    } sched_state_e;

    // One buffered DUT retire event, as seen by the ISS
    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic               intr;
        logic [CAUSE_W-1:0] cause;
    } retire_entry_t;

endpackage

// File: rtl/rm_sched_fifo.sv
// Small synchronous FIFO holding retire events until the ISS steps them.
// The head entry is read combinationally so it is valid the same cycle the
// scheduler starts a step.
module rm_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 76
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    import rm_sched_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;

    // Storage write; contents need no reset because occupancy gates reads
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_reg] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push_i && !pop_i) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (!push_i && pop_i) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

    assign rdata_o = mem[rd_ptr_reg];
    assign full_o  = (count_reg == FULL_CNT);
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;

endmodule

// File: rtl/rm_step_scheduler.sv
// Lock-step scheduler between the DUT RVFI monitor and the ISS step wrapper.
// Buffers retires, tags them with interrupts that became pending before (or
// with) them, forwards interrupt-line changes, and issues one ISS step per
// retire through a req/ack handshake.
module rm_step_scheduler #(
    parameter int DEPTH   = 4,
    parameter int IRQ_W   = 32,
    parameter int ORDER_W = 64,
    parameter int CAUSE_W = 11
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       retire_valid_i,
    input  logic [ORDER_W-1:0]         retire_order_i,
    input  logic [IRQ_W-1:0]           irq_i,
    output logic                       irq_update_o,
    output logic [IRQ_W-1:0]           irq_vec_o,
    output logic                       step_req_o,
    input  logic                       step_ack_i,
    output logic [ORDER_W-1:0]         step_order_o,
    output logic                       step_intr_o,
    output logic [CAUSE_W-1:0]         step_cause_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);
    import rm_sched_pkg::*;

    // Entry layout inside the FIFO: {order, intr, cause}
    localparam int ENTRY_W = ORDER_W + 1 + CAUSE_W;

    sched_state_e state_reg, state_next;

    logic [IRQ_W-1:0]   irq_q;
    logic [IRQ_W-1:0]   irq_vec_reg;
    logic               upd_pend_reg;
    logic               intr_pend_reg;
    logic [CAUSE_W-1:0] intr_cause_reg;
    logic               overflow_reg;

    logic               irq_change;
    logic               irq_new_intr;
    logic [CAUSE_W-1:0] irq_cause;
    logic               tag_intr;
    logic [CAUSE_W-1:0] tag_cause;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    // Cause is the index of the lowest set interrupt line (scan high to low,
    // so the last hit wins)
    always_comb begin
        irq_cause = '0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (irq_i[i]) begin
                irq_cause = CAUSE_W'(i);
            end
        end
    end

    assign irq_change   = (irq_i != irq_q);
    assign irq_new_intr = irq_change && (|irq_i);

    // A change arriving in the same cycle as a retire tags that retire
    assign tag_intr  = irq_new_intr || intr_pend_reg;
    assign tag_cause = irq_new_intr ? irq_cause : intr_cause_reg;

    // Untagged entries carry a zero cause so stale causes never leak out
    assign fifo_wdata = {retire_order_i, tag_intr, (tag_intr ? tag_cause : {CAUSE_W{1'b0}})};

    // Pop only on an acknowledged step; a full FIFO still accepts a push
    // when it pops in the same cycle
    assign pop  = (state_reg == STEP) && step_ack_i;
    assign push = retire_valid_i && (!fifo_full || pop);

    rm_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    // Interrupt-line sampling, change latching and pending-update flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q        <= '0;
            irq_vec_reg  <= '0;
            upd_pend_reg <= 1'b0;
        end else begin
            irq_q <= irq_i;
            if (irq_change) begin
                irq_vec_reg  <= irq_i;
                upd_pend_reg <= 1'b1;
            end else if (state_reg == IRQ_UPD) begin
                upd_pend_reg <= 1'b0;
            end
        end
    end

    // Pending interrupt tag: consumed by an accepted retire, kept on a drop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intr_pend_reg  <= 1'b0;
            intr_cause_reg <= '0;
        end else begin
            if (push) begin
                intr_pend_reg <= 1'b0;
            end else if (irq_new_intr) begin
                intr_pend_reg <= 1'b1;
            end
            if (irq_new_intr && !push) begin
                intr_cause_reg <= irq_cause;
            end
        end
    end

    // Sticky record of any retire dropped because the FIFO was full
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_reg <= 1'b0;
        end else if (retire_valid_i && !push) begin
            overflow_reg <= 1'b1;
        end
    end

    // Scheduler state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; updates win only when idle, a step
    // in flight always runs to its ack
    always_comb begin
        state_next   = state_reg;
        irq_update_o = 1'b0;
        step_req_o   = 1'b0;
        step_order_o = '0;
        step_intr_o  = 1'b0;
        step_cause_o = '0;
        unique case (state_reg)
            IDLE: begin
                if (upd_pend_reg) begin
                    state_next = IRQ_UPD;
                end else if (!fifo_empty) begin
                    state_next = STEP;
                end
            end
            IRQ_UPD: begin
                irq_update_o = 1'b1;
                state_next   = IDLE;
            end
            STEP: begin
                step_req_o   = 1'b1;
                step_order_o = fifo_rdata[ENTRY_W-1 -: ORDER_W];
                step_intr_o  = fifo_rdata[CAUSE_W];
                step_cause_o = fifo_rdata[CAUSE_W-1:0];
                if (step_ack_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign irq_vec_o  = irq_vec_reg;
    assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_rm_step_scheduler.sv
// Bench for rm_step_scheduler: a directed cycle table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_rm_step_scheduler;

    localparam int DEPTH   = 4;
    localparam int IRQ_W   = 32;
    localparam int ORDER_W = 64;
    localparam int CAUSE_W = 11;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               clk_i;
    logic               rst_ni;
    logic               retire_valid_i;
    logic [ORDER_W-1:0] retire_order_i;
    logic [IRQ_W-1:0]   irq_i;
    logic               irq_update_o;
    logic [IRQ_W-1:0]   irq_vec_o;
    logic               step_req_o;
    logic               step_ack_i;
    logic [ORDER_W-1:0] step_order_o;
    logic               step_intr_o;
    logic [CAUSE_W-1:0] step_cause_o;
    logic [CNT_W-1:0]   count_o;
    logic               overflow_o;

    rm_step_scheduler #(
        .DEPTH   (DEPTH),
        .IRQ_W   (IRQ_W),
        .ORDER_W (ORDER_W),
        .CAUSE_W (CAUSE_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .retire_valid_i (retire_valid_i),
        .retire_order_i (retire_order_i),
        .irq_i          (irq_i),
        .irq_update_o   (irq_update_o),
        .irq_vec_o      (irq_vec_o),
        .step_req_o     (step_req_o),
        .step_ack_i     (step_ack_i),
        .step_order_o   (step_order_o),
        .step_intr_o    (step_intr_o),
        .step_cause_o   (step_cause_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- counters and compare helper ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [63:0] order;
        logic        intr;
        logic [10:0] cause;
    } mentry_t;

    mentry_t     mq[$];
    logic [31:0] m_irq_q;
    logic [31:0] m_vec;
    logic        m_ip;
    logic [10:0] m_ipc;
    logic        m_upd;
    logic        m_ovf;
    logic        prev_pop;
    logic [31:0] cur_irq;

    function automatic logic [10:0] lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return 11'(i);
        end
        return 11'd0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_irq_q  = '0;
        m_vec    = '0;
        m_ip     = 1'b0;
        m_ipc    = '0;
        m_upd    = 1'b0;
        m_ovf    = 1'b0;
        prev_pop = 1'b0;
    endtask

    // One clock cycle: check outputs against the model, apply inputs,
    // advance the model, then step past the next rising edge.
    task automatic cycle(input logic rv, input logic [63:0] ord, input logic [31:0] irq, input logic ack);
        logic    popn;
        logic    acc;
        logic    chg;
        mentry_t e;
        chk("count", 64'(count_o), 64'(mq.size()));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        if (step_req_o) begin
            chk("step_gap", 64'(prev_pop), 64'd0);
            chk("step_nonempty", 64'(mq.size() > 0), 64'd1);
            if (mq.size() > 0) begin
                chk("step_order", step_order_o, mq[0].order);
                chk("step_intr", 64'(step_intr_o), 64'(mq[0].intr));
                chk("step_cause", 64'(step_cause_o), 64'(mq[0].cause));
            end
        end
        if (irq_update_o) begin
            chk("upd_expected", 64'(m_upd), 64'd1);
            chk("upd_vec", 64'(irq_vec_o), 64'(m_vec));
        end
        retire_valid_i = rv;
        retire_order_i = ord;
        irq_i          = irq;
        step_ack_i     = ack;
        popn = step_req_o && ack;
        acc  = (mq.size() < DEPTH) || popn;
        chg  = (irq != m_irq_q);
        if (irq_update_o && !chg) m_upd = 1'b0;
        if (chg) begin
            m_upd = 1'b1;
            m_vec = irq;
            if (irq != 0) begin
                m_ip  = 1'b1;
                m_ipc = lowest(irq);
            end
        end
        if (popn) void'(mq.pop_front());
        if (rv) begin
            if (acc) begin
                e.order = ord;
                e.intr  = m_ip;
                e.cause = m_ip ? m_ipc : 11'd0;
                mq.push_back(e);
                m_ip = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
        end
        prev_pop = popn;
        m_irq_q  = irq;
        @(posedge clk_i);
        #1;
    endtask

    // Wait (bounded) for a step request, check it explicitly, then ack it
    task automatic wait_step(input logic [63:0] e_ord, input logic e_intr, input logic [10:0] e_cause);
        int n;
        n = 0;
        while (!step_req_o && n < 30) begin
            cycle(1'b0, 64'd0, cur_irq, 1'b0);
            n++;
        end
        chk("wait_step_seen", 64'(step_req_o), 64'd1);
        if (step_req_o) begin
            chk("ws_order", step_order_o, e_ord);
            chk("ws_intr", 64'(step_intr_o), 64'(e_intr));
            chk("ws_cause", 64'(step_cause_o), 64'(e_cause));
            cycle(1'b0, 64'd0, cur_irq, 1'b1);
        end
    endtask

    // Wait (bounded) for an interrupt update pulse and check its vector
    task automatic wait_update(input logic [31:0] e_vec);
        int n;
        n = 0;
        while (!irq_update_o && n < 30) begin
            cycle(1'b0, 64'd0, cur_irq, 1'b0);
            n++;
        end
        chk("wait_upd_seen", 64'(irq_update_o), 64'd1);
        if (irq_update_o) begin
            chk("wu_vec", 64'(irq_vec_o), 64'(e_vec));
            cycle(1'b0, 64'd0, cur_irq, 1'b0);
        end
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic        rv;
        logic [63:0] ord;
        logic [31:0] irq;
        logic        ack;
        logic        e_req;
        logic        e_upd;
        logic [31:0] e_vec;
        logic [63:0] e_ord;
        logic        e_intr;
        logic [10:0] e_cause;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic rv, input logic [63:0] ord, input logic [31:0] irq,
                                input logic ack, input logic e_req, input logic e_upd,
                                input logic [31:0] e_vec, input logic [63:0] e_ord,
                                input logic e_intr, input logic [10:0] e_cause, input logic [2:0] e_cnt);
        vec_t v;
        v.rv = rv; v.ord = ord; v.irq = irq; v.ack = ack;
        v.e_req = e_req; v.e_upd = e_upd; v.e_vec = e_vec; v.e_ord = e_ord;
        v.e_intr = e_intr; v.e_cause = e_cause; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        logic        r_rv;
        logic        r_ack;
        logic [63:0] ord_ctr;
        int          n;

        rst_ni         = 1'b0;
        retire_valid_i = 1'b0;
        retire_order_i = '0;
        irq_i          = '0;
        step_ack_i     = 1'b0;
        cur_irq        = '0;
        model_reset();

        // Reset state
        #2;
        chk("rst_req", 64'(step_req_o), 64'd0);
        chk("rst_upd", 64'(irq_update_o), 64'd0);
        chk("rst_vec", 64'(irq_vec_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_order", step_order_o, 64'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single retire (order 5, ack after 3 cycles), then irq 0->0x8 and retire 7
        //           rv ord  irq   ack | req upd vec  ord intr cause cnt
        tbl[0]  = mk(1, 5, 32'h0, 0,    0,  0,  0,   0,  0,   0,    0);
        tbl[1]  = mk(0, 0, 32'h0, 0,    0,  0,  0,   0,  0,   0,    1);
        tbl[2]  = mk(0, 0, 32'h0, 0,    1,  0,  0,   5,  0,   0,    1);
        tbl[3]  = mk(0, 0, 32'h0, 0,    1,  0,  0,   5,  0,   0,    1);
        tbl[4]  = mk(0, 0, 32'h0, 1,    1,  0,  0,   5,  0,   0,    1);
        tbl[5]  = mk(0, 0, 32'h0, 0,    0,  0,  0,   0,  0,   0,    0);
        tbl[6]  = mk(0, 0, 32'h0, 0,    0,  0,  0,   0,  0,   0,    0);
        tbl[7]  = mk(0, 0, 32'h8, 0,    0,  0,  0,   0,  0,   0,    0);
        tbl[8]  = mk(1, 7, 32'h8, 0,    0,  0,  8,   0,  0,   0,    0);
        tbl[9]  = mk(0, 0, 32'h8, 0,    0,  1,  8,   0,  0,   0,    1);
        tbl[10] = mk(0, 0, 32'h8, 0,    0,  0,  8,   0,  0,   0,    1);
        tbl[11] = mk(0, 0, 32'h8, 1,    1,  0,  8,   7,  1,   3,    1);
        tbl[12] = mk(0, 0, 32'h8, 0,    0,  0,  8,   0,  0,   0,    0);

        for (int i = 0; i < 13; i++) begin
            chk($sformatf("t%0d_req", i), 64'(step_req_o), 64'(tbl[i].e_req));
            chk($sformatf("t%0d_upd", i), 64'(irq_update_o), 64'(tbl[i].e_upd));
            chk($sformatf("t%0d_vec", i), 64'(irq_vec_o), 64'(tbl[i].e_vec));
            chk($sformatf("t%0d_ord", i), step_order_o, tbl[i].e_ord);
            chk($sformatf("t%0d_intr", i), 64'(step_intr_o), 64'(tbl[i].e_intr));
            chk($sformatf("t%0d_cause", i), 64'(step_cause_o), 64'(tbl[i].e_cause));
            chk($sformatf("t%0d_cnt", i), 64'(count_o), 64'(tbl[i].e_cnt));
            $display("table row %0d: req=%0d upd=%0d ord=%0d cnt=%0d", i, step_req_o, irq_update_o, step_order_o, count_o);
            cycle(tbl[i].rv, tbl[i].ord, tbl[i].irq, tbl[i].ack);
        end
        cur_irq = 32'h8;

        // IRQ change and retire in the same cycle: that retire tagged, next untagged
        cur_irq = 32'h880;
        cycle(1'b1, 64'd9, cur_irq, 1'b0);
        cycle(1'b1, 64'd10, cur_irq, 1'b0);
        wait_step(64'd9, 1'b1, 11'd7);
        wait_step(64'd10, 1'b0, 11'd0);
        $display("same-cycle tag sequence done");

        // Five back-to-back retires with ack held low: fifth dropped
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 64'(i), cur_irq, 1'b0);
        end
        chk("full_count", 64'(count_o), 64'd4);
        chk("full_ovf", 64'(overflow_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            wait_step(64'(i), 1'b0, 11'd0);
        end
        chk("ovf_sticky", 64'(overflow_o), 64'd1);
        $display("overflow sequence done");

        // 0x880 -> 0x8 tags the next retire; 0x8 -> 0 forwards zero, no tag
        cur_irq = 32'h8;
        cycle(1'b0, 64'd0, cur_irq, 1'b0);
        wait_update(32'h8);
        cycle(1'b1, 64'd11, cur_irq, 1'b0);
        wait_step(64'd11, 1'b1, 11'd3);
        cur_irq = 32'h0;
        cycle(1'b0, 64'd0, cur_irq, 1'b0);
        wait_update(32'h0);
        cycle(1'b1, 64'd20, cur_irq, 1'b0);
        wait_step(64'd20, 1'b0, 11'd0);
        $display("irq clear sequence done");

        // Reset in the middle of a step with three entries queued
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 64'(30 + i), cur_irq, 1'b0);
        end
        n = 0;
        while (!step_req_o && n < 10) begin
            cycle(1'b0, 64'd0, cur_irq, 1'b0);
            n++;
        end
        chk("pre_rst_req", 64'(step_req_o), 64'd1);
        chk("pre_rst_count", 64'(count_o), 64'd3);
        retire_valid_i = 1'b0;
        step_ack_i     = 1'b0;
        rst_ni         = 1'b0;
        #1;
        chk("mid_rst_req", 64'(step_req_o), 64'd0);
        chk("mid_rst_order", step_order_o, 64'd0);
        chk("mid_rst_count", 64'(count_o), 64'd0);
        chk("mid_rst_ovf", 64'(overflow_o), 64'd0);
        chk("mid_rst_upd", 64'(irq_update_o), 64'd0);
        step_ack_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 64'd0, cur_irq, 1'b1);
        end
        chk("post_rst_count", 64'(count_o), 64'd0);
        chk("post_rst_req", 64'(step_req_o), 64'd0);
        $display("reset-mid-step sequence done");

        // Randomized run against the model
        ord_ctr = 64'd100;
        for (int k = 0; k < 1500; k++) begin
            r_rv  = ($urandom_range(0, 99) < 45);
            r_ack = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 8) begin
                if ($urandom_range(0, 3) == 0) cur_irq = 32'h0;
                else cur_irq = (32'h1 << $urandom_range(0, 31)) | ($urandom() & $urandom());
            end
            cycle(r_rv, ord_ctr, cur_irq, r_ack);
            if (r_rv) ord_ctr++;
        end

        // Drain everything still queued or pending
        n = 0;
        while ((mq.size() != 0 || m_upd || step_req_o || irq_update_o) && n < 100) begin
            cycle(1'b0, 64'd0, cur_irq, 1'b1);
            n++;
        end
        chk("drain_model_empty", 64'(mq.size()), 64'd0);
        chk("drain_count", 64'(count_o), 64'd0);
        $display("random run done, last order %0d", ord_ctr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rm_step_scheduler.md
# rm_step_scheduler

Sequences the ISS reference model against DUT retirement in the lock-step RVFI comparison path. Buffers DUT retire events, tags each with any interrupt that became pending before it, forwards interrupt-line changes to the ISS, and issues one step request per retire through a req/ack handshake. Sits between the DUT RVFI monitor and the ISS step wrapper, so the wrapper no longer steps blindly on every `rvfi_valid`.

## Interface
- `DEPTH`, 4: retire FIFO entries (power of two, ≥2)
- `IRQ_W`, 32: interrupt line width
- `ORDER_W`, 64: retire order tag width
- `CAUSE_W`, 11: cause field width
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `retire_valid_i` in 1: DUT retired one instruction this cycle
- `retire_order_i` in ORDER_W: RVFI order of that instruction
- `irq_i` in IRQ_W: interrupt lines as driven to the DUT
- `irq_update_o` out 1: one-cycle pulse; ISS must apply `irq_vec_o`
- `irq_vec_o` out IRQ_W: interrupt vector to forward
- `step_req_o` out 1: request one ISS step
- `step_ack_i` in 1: ISS step complete
- `step_order_o` out ORDER_W: order of the entry being stepped
- `step_intr_o` out 1: this step takes an interrupt
- `step_cause_o` out CAUSE_W: interrupt cause for this step
- `count_o` out $clog2(DEPTH)+1: FIFO occupancy
- `overflow_o` out 1: sticky; a retire was dropped

## Operation
- Reset values: every output 0; FIFO empty; FSM IDLE; `irq_q`, pending flags and latched vector 0.
- IRQ detect: `irq_q <= irq_i` each cycle. `irq_i != irq_q` sets `upd_pend`, latches `irq_vec` (latest wins if several changes precede forwarding). If the new value is nonzero, also sets `intr_pend` with cause = index of lowest set bit of `irq_i`.
- Enqueue: on `retire_valid_i`, push {order, intr_pend, cause}; clear `intr_pend` in the same cycle. Change and retire in the same cycle: that retire is tagged.
- Full: push accepted if `count < DEPTH` or a pop occurs the same cycle; otherwise dropped, `overflow_o` set until reset, `intr_pend` stays set.
- FSM:
  - IDLE: if `upd_pend` -> IRQ_UPD; else if FIFO non-empty -> STEP.
  - IRQ_UPD: `irq_update_o`=1 for exactly one cycle, clear `upd_pend` (unless a new change arrives that cycle) -> IDLE.
  - STEP: `step_req_o`=1, step_* driven from FIFO head, held stable until `step_ack_i`; on ack pop -> IDLE.
- IRQ update has priority over a step only at IDLE; an in-flight STEP is never preempted.
- `step_ack_i` outside STEP is ignored.

## Timing
- IRQ change at edge N: `irq_update_o` earliest cycle N+2 (detect N+1, IDLE->IRQ_UPD).
- Retire at edge N into empty FIFO, no update pending: `step_req_o` high from N+2.
- Ack sampled at edge with `step_req_o` high completes the step; ack in the first STEP cycle is legal; `step_req_o` low for at least one cycle (IDLE) between steps.
- Throughput: one step per 2 cycles at zero-wait ack.
- `count_o` reflects pushes/pops registered at the previous edge.
- Reset asserted mid-STEP: outputs drop to 0 immediately (async); FIFO content lost; late ack after reset release ignored.

## Structure
- Shared package `rm_sched_pkg`: FSM state enum (IDLE, IRQ_UPD, STEP), retire entry struct {order, intr, cause}, `CAUSE_W` constant.
- One sub-module: `rm_sched_fifo` (parameterised sync FIFO, DEPTH entries, push/pop/full/empty/count, async active-low reset).

## Test plan
- Single retire order 5, no IRQ, ack after 3 cycles -> `step_req_o` high 3 cycles, `step_order_o`=5, `step_intr_o`=0, one pop, `count_o` back to 0.
- `irq_i` 0->0x8 then retire order 7 next cycle -> `irq_update_o` pulse with `irq_vec_o`=0x8 before `step_req_o`; step has `step_intr_o`=1, `step_cause_o`=3.
- IRQ change and retire same cycle (`irq_i`=0x880) -> that retire tagged, cause=7; following retire untagged.
- Five back-to-back retires, DEPTH=4, ack held low -> `count_o`=4, fifth dropped, `overflow_o`=1 sticky; acks then yield orders 0-3 in order.
- `irq_i` 0x8->0x0 -> `irq_update_o` with vector 0, no subsequent step tagged.
- Assert `rst_ni` low during STEP with 3 entries queued -> all outputs 0 that cycle; after release `count_o`=0, stray `step_ack_i` causes no pop.
